// File: rtl/rf_exec_pkg.sv
// Shared definitions for the register-file execute stage.
// Holds default widths, ALU opcode and shifter encodings, and the
// sequencer state encoding used by rf_exec_stage.
package rf_exec_pkg;

  localparam int DW_DEF = 16;
  localparam int RW_DEF = 3;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

endpackage

// File: rtl/rf_exec_alu.sv
// Combinational shifter + ALU + flag generation for rf_exec_stage.
// Ports:
//   a, b      latched operand registers (b goes through the shifter)
//   imm       immediate, replaces shifted b when bsel=1
//   asel      force operand A to zero
//   bsel      select imm as operand B
//   alu_op    ADD / SUB / AND / MVN
//   shift     NONE / LSL1 / LSR1 / ASR1 applied to b
//   c         ALU result
//   flags     {Z,N,V}
module rf_exec_alu
  import rf_exec_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] imm,
  input  logic          asel,
  input  logic          bsel,
  input  logic [1:0]    alu_op,
  input  logic [1:0]    shift,
  output logic [DW-1:0] c,
  output logic [2:0]    flags
);

  logic [DW-1:0] b_sh;
  logic [DW-1:0] ain;
  logic [DW-1:0] bin;
  logic          v;

  always_comb begin
    b_sh = b;
    case (shift)
      SH_LSL:  b_sh = {b[DW-2:0], 1'b0};
      SH_LSR:  b_sh = {1'b0, b[DW-1:1]};
      SH_ASR:  b_sh = {b[DW-1], b[DW-1:1]};
      default: b_sh = b;
    endcase

    ain = asel ? '0 : a;
    bin = bsel ? imm : b_sh;

    c = '0;
    v = 1'b0;
    case (alu_op)
      OP_ADD: begin
        c = ain + bin;
        v = (ain[DW-1] == bin[DW-1]) && (c[DW-1] != ain[DW-1]);
      end
      OP_SUB: begin
        c = ain - bin;
        v = (ain[DW-1] != bin[DW-1]) && (c[DW-1] != ain[DW-1]);
      end
      OP_AND:  c = ain & bin;
      default: c = ~bin;
    endcase

    flags = {(c == '0), c[DW-1], v};
  end

endmodule

// File: rtl/rf_exec_stage.sv
// Multi-cycle execute stage sitting behind an 8x16 register file.
// Reads Rn then Rm through the file's single read port, runs the
// shifter/ALU, latches result and {Z,N,V}, and writes back to Rd.
//
//   state  | meaning
//   -------+-------------------------------------------
//   IDLE   | waiting for start; fields latched on start
//   RD_A   | readnum=Rn, capture A
//   RD_B   | readnum=Rm, capture B
//   EXEC   | capture C and status from the ALU
//   WB     | write C to Rd if wb_en, pulse done
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   start              launch request (IDLE only)
//   rn, rm, rd         operand / destination register indices
//   alu_op, shift      operation and B-shift select
//   asel, bsel, imm    operand overrides
//   wb_en              enable write-back (0 = flags only)
//   rf_rdata           register file read data
//   rf_readnum         register file read index
//   rf_writenum        register file write index
//   rf_write, rf_wdata register file write enable / data
//   busy, done         handshake
//   result, status     latched C and {Z,N,V}
module rf_exec_stage
  import rf_exec_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [RW-1:0] rn,
  input  logic [RW-1:0] rm,
  input  logic [RW-1:0] rd,
  input  logic [1:0]    alu_op,
  input  logic [1:0]    shift,
  input  logic          asel,
  input  logic          bsel,
  input  logic [DW-1:0] imm,
  input  logic          wb_en,
  input  logic [DW-1:0] rf_rdata,
  output logic [RW-1:0] rf_readnum,
  output logic [RW-1:0] rf_writenum,
  output logic          rf_write,
  output logic [DW-1:0] rf_wdata,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result,
  output logic [2:0]    status
);

  state_t state_q, state_d;

  logic [RW-1:0] rn_q, rm_q, rd_q;
  logic [1:0]    alu_op_q, shift_q;
  logic          asel_q, bsel_q, wb_en_q;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] a_q, b_q, c_q;
  logic [2:0]    status_q;

  logic [DW-1:0] alu_c;
  logic [2:0]    alu_flags;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RD_A;
      S_RD_A:  state_d = S_RD_B;
      S_RD_B:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rf_readnum = '0;
    case (state_q)
      S_RD_A:  rf_readnum = rn_q;
      S_RD_B:  rf_readnum = rm_q;
      default: rf_readnum = '0;
    endcase
    rf_write = (state_q == S_WB) && wb_en_q;
    done     = (state_q == S_WB);
    busy     = (state_q != S_IDLE);
  end

  assign rf_writenum = rd_q;
  assign rf_wdata    = c_q;
  assign result      = c_q;
  assign status      = status_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rn_q     <= '0;
      rm_q     <= '0;
      rd_q     <= '0;
      alu_op_q <= '0;
      shift_q  <= '0;
      asel_q   <= 1'b0;
      bsel_q   <= 1'b0;
      imm_q    <= '0;
      wb_en_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        rn_q     <= rn;
        rm_q     <= rm;
        rd_q     <= rd;
        alu_op_q <= alu_op;
        shift_q  <= shift;
        asel_q   <= asel;
        bsel_q   <= bsel;
        imm_q    <= imm;
        wb_en_q  <= wb_en;
      end
      if (state_q == S_RD_A) a_q <= rf_rdata;
      if (state_q == S_RD_B) b_q <= rf_rdata;
      if (state_q == S_EXEC) begin
        c_q      <= alu_c;
        status_q <= alu_flags;
      end
    end
  end

  rf_exec_alu #(.DW(DW)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .imm    (imm_q),
    .asel   (asel_q),
    .bsel   (bsel_q),
    .alu_op (alu_op_q),
    .shift  (shift_q),
    .c      (alu_c),
    .flags  (alu_flags)
  );

endmodule

// File: tb/tb_rf_exec_stage.sv
module tb_rf_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  rn, rm, rd;
  logic [1:0]  alu_op, shift;
  logic        asel, bsel, wb_en;
  logic [15:0] imm;
  logic [15:0] rf_rdata;
  logic [2:0]  rf_readnum, rf_writenum;
  logic        rf_write;
  logic [15:0] rf_wdata;
  logic        busy, done;
  logic [15:0] result;
  logic [2:0]  status;

  int tests = 0;
  int fails = 0;

  // Register file: combinational read, write on rising edge.
  // tb_ld lets the bench preload values while the stage is idle.
  logic [15:0] rf [8];
  logic        tb_ld;
  logic [2:0]  tb_idx;
  logic [15:0] tb_val;

  always @(posedge clk) begin
    if (tb_ld)         rf[tb_idx]      <= tb_val;
    else if (rf_write) rf[rf_writenum] <= rf_wdata;
  end
  assign rf_rdata = rf[rf_readnum];

  always #5 clk = ~clk;

  rf_exec_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .rn          (rn),
    .rm          (rm),
    .rd          (rd),
    .alu_op      (alu_op),
    .shift       (shift),
    .asel        (asel),
    .bsel        (bsel),
    .imm         (imm),
    .wb_en       (wb_en),
    .rf_rdata    (rf_rdata),
    .rf_readnum  (rf_readnum),
    .rf_writenum (rf_writenum),
    .rf_write    (rf_write),
    .rf_wdata    (rf_wdata),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .status      (status)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reg(input logic [2:0] idx, input logic [15:0] val);
    tb_ld = 1'b1; tb_idx = idx; tb_val = val;
    tick();
    tb_ld = 1'b0;
  endtask

  // Launch one operation and check every cycle through return to IDLE.
  // Inputs are scrambled after the start edge to prove they were latched.
  task automatic do_op(input string tag,
                       input logic [2:0] a_rn, input logic [2:0] a_rm, input logic [2:0] a_rd,
                       input logic [1:0] a_op, input logic [1:0] a_sh,
                       input logic a_asel, input logic a_bsel, input logic [15:0] a_imm,
                       input logic a_wb, input logic [15:0] e_c, input logic [2:0] e_st);
    rn = a_rn; rm = a_rm; rd = a_rd; alu_op = a_op; shift = a_sh;
    asel = a_asel; bsel = a_bsel; imm = a_imm; wb_en = a_wb; start = 1'b1;
    tick();
    start = 1'b0;
    rn = ~a_rn; rm = ~a_rm; rd = ~a_rd; alu_op = ~a_op; shift = ~a_sh;
    asel = ~a_asel; bsel = ~a_bsel; imm = ~a_imm; wb_en = ~a_wb;
    chk({tag, " busy_rda"}, 16'(busy), 16'd1);
    chk({tag, " done_rda"}, 16'(done), 16'd0);
    chk({tag, " readnum_a"}, 16'(rf_readnum), 16'(a_rn));
    tick();
    chk({tag, " readnum_b"}, 16'(rf_readnum), 16'(a_rm));
    chk({tag, " write_rdb"}, 16'(rf_write), 16'd0);
    tick();
    chk({tag, " readnum_ex"}, 16'(rf_readnum), 16'd0);
    chk({tag, " done_ex"}, 16'(done), 16'd0);
    tick();
    chk({tag, " done_wb"}, 16'(done), 16'd1);
    chk({tag, " busy_wb"}, 16'(busy), 16'd1);
    chk({tag, " write_wb"}, 16'(rf_write), 16'(a_wb));
    chk({tag, " writenum"}, 16'(rf_writenum), 16'(a_rd));
    chk({tag, " wdata"}, rf_wdata, e_c);
    chk({tag, " result"}, result, e_c);
    chk({tag, " status"}, 16'(status), 16'(e_st));
    tick();
    chk({tag, " busy_idle"}, 16'(busy), 16'd0);
    chk({tag, " done_idle"}, 16'(done), 16'd0);
    chk({tag, " write_idle"}, 16'(rf_write), 16'd0);
    if (a_wb) chk({tag, " rd_value"}, rf[a_rd], e_c);
  endtask

  initial begin
    int done_cnt;
    rst_n = 1'b0; start = 1'b0; rn = '0; rm = '0; rd = '0; alu_op = '0; shift = '0;
    asel = 1'b0; bsel = 1'b0; imm = '0; wb_en = 1'b0;
    tb_ld = 1'b0; tb_idx = '0; tb_val = '0;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
    tick(); tick();
    chk("rst busy", 16'(busy), 16'd0);
    chk("rst done", 16'(done), 16'd0);
    chk("rst write", 16'(rf_write), 16'd0);
    chk("rst readnum", 16'(rf_readnum), 16'd0);
    chk("rst result", result, 16'h0000);
    chk("rst status", 16'(status), 16'd0);
    rst_n = 1'b1;
    tick();

    // basic ADD
    set_reg(3'd1, 16'h0007); set_reg(3'd2, 16'h0005); set_reg(3'd7, 16'hAAAA);
    do_op("add", 3'd1, 3'd2, 3'd3, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h000C, 3'b000);

    // CMP-style SUB, no write-back
    set_reg(3'd1, 16'h0005);
    do_op("cmp", 3'd1, 3'd2, 3'd7, 2'b01, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b100);
    chk("cmp r7", rf[7], 16'hAAAA);
    chk("cmp r1", rf[1], 16'h0005);
    chk("cmp r3", rf[3], 16'h000C);

    // signed overflow
    set_reg(3'd1, 16'h7FFF); set_reg(3'd2, 16'h0001);
    do_op("addv", 3'd1, 3'd2, 3'd4, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h8000, 3'b011);
    set_reg(3'd1, 16'h8000);
    do_op("subv", 3'd1, 3'd2, 3'd4, 2'b01, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h7FFF, 3'b001);

    // shifter with asel
    set_reg(3'd2, 16'h8004);
    do_op("asr", 3'd1, 3'd2, 3'd5, 2'b00, 2'b11, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hC002, 3'b010);
    do_op("lsr", 3'd1, 3'd2, 3'd5, 2'b00, 2'b10, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h4002, 3'b000);
    do_op("lsl", 3'd1, 3'd2, 3'd5, 2'b00, 2'b01, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0008, 3'b000);

    // immediate MVN
    do_op("mvn", 3'd1, 3'd2, 3'd6, 2'b11, 2'b00, 1'b0, 1'b1, 16'h00FF, 1'b1, 16'hFF00, 3'b010);

    // AND
    set_reg(3'd1, 16'hF0F0); set_reg(3'd2, 16'h3C3C);
    do_op("and", 3'd1, 3'd2, 3'd7, 2'b10, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h3030, 3'b000);

    // back-to-back read-after-write
    set_reg(3'd1, 16'h0003);
    do_op("raw1", 3'd1, 3'd1, 3'd1, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 3'b000);
    do_op("raw2", 3'd1, 3'd1, 3'd1, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h000C, 3'b000);

    // start pulses in RD_B and WB are ignored
    set_reg(3'd1, 16'h0002); set_reg(3'd2, 16'h0001);
    rn = 3'd1; rm = 3'd2; rd = 3'd3; alu_op = 2'b00; shift = 2'b00;
    asel = 1'b0; bsel = 1'b0; imm = 16'h0000; wb_en = 1'b1; start = 1'b1;
    done_cnt = 0;
    tick();
    start = 1'b0;
    tick();                       // RD_B
    start = 1'b1; rd = 3'd5;
    tick();                       // EXEC
    start = 1'b0;
    if (done) done_cnt++;
    tick();                       // WB
    if (done) done_cnt++;
    start = 1'b1;
    chk("ign wdata", rf_wdata, 16'h0003);
    chk("ign writenum", 16'(rf_writenum), 16'd3);
    tick();                       // IDLE
    start = 1'b0;
    chk("ign busy", 16'(busy), 16'd0);
    for (int i = 0; i < 6; i++) begin
      if (done) done_cnt++;
      tick();
    end
    chk("ign done count", 16'(done_cnt), 16'd1);
    chk("ign r3", rf[3], 16'h0003);
    chk("ign r5", rf[5], 16'h0008);

    // reset during EXEC aborts without writing
    rn = 3'd1; rm = 3'd2; rd = 3'd6; alu_op = 2'b00; wb_en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();               // EXEC
    chk("abort in exec", 16'(busy), 16'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort busy", 16'(busy), 16'd0);
    chk("abort done", 16'(done), 16'd0);
    chk("abort status", 16'(status), 16'd0);
    chk("abort result", result, 16'h0000);
    chk("abort write", 16'(rf_write), 16'd0);
    chk("abort readnum", 16'(rf_readnum), 16'd0);
    tick(); tick(); tick();
    chk("abort r6", rf[6], 16'hFF00);
    do_op("post", 3'd1, 3'd2, 3'd4, 2'b01, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
